// File: rtl/ntt_butterfly_array.sv
// ntt_butterfly_array: LANES-wide, 4-stage pipelined CT/GS modular butterfly
// using Shoup multiplication.  Rev 1.0
`default_nettype none

module ntt_butterfly_array #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   mode,
  input  logic [LANES*WIDTH-1:0] cin_a,
  input  logic [LANES*WIDTH-1:0] cin_b,
  input  logic [LANES*WIDTH-1:0] w,
  input  logic [LANES*WIDTH-1:0] wp,
  input  logic [WIDTH-1:0]       q,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] cout_a,
  output logic [LANES*WIDTH-1:0] cout_b,
  output logic                   busy
);

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, m};
    return d[WIDTH-1:0];
  endfunction

  logic v1_q, v2_q, v3_q, v4_q;
  logic mode1_q, mode2_q, mode3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      mode1_q <= 1'b0;
      mode2_q <= 1'b0;
      mode3_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
      if (in_valid) mode1_q <= mode;
      if (v1_q)     mode2_q <= mode1_q;
      if (v2_q)     mode3_q <= mode2_q;
    end
  end

  assign out_valid = v4_q;
  assign busy      = v1_q | v2_q | v3_q | v4_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] a1_q, b1_q, w1_q, wp1_q;
    logic [WIDTH-1:0] a2_q, m2_q, sum2_q, w2_q, wp2_q;
    logic [WIDTH-1:0] a3_q, sum3_q, qh3_q, lo3_q;
    logic [WIDTH-1:0] ca_q, cb_q;

    logic [WIDTH-1:0] m2_d, sum2_d, qh3_d, lo3_d, r_d, t_d, ca_d, cb_d;

    assign m2_d   = mode1_q ? sub_mod(a1_q, b1_q, q) : b1_q;
    assign sum2_d = add_mod(a1_q, b1_q, q);

    // Quotient estimate needs the full high half; the remainder only the low half.
    assign qh3_d = WIDTH'(({{WIDTH{1'b0}}, m2_q} * {{WIDTH{1'b0}}, wp2_q}) >> WIDTH);
    assign lo3_d = m2_q * w2_q;

    assign r_d = lo3_q - qh3_q * q;
    assign t_d = (r_d >= q) ? (r_d - q) : r_d;

    always_comb begin
      ca_d = add_mod(a3_q, t_d, q);
      cb_d = sub_mod(a3_q, t_d, q);
      if (mode3_q) begin
        ca_d = sum3_q;
        cb_d = t_d;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        a1_q   <= '0;
        b1_q   <= '0;
        w1_q   <= '0;
        wp1_q  <= '0;
        a2_q   <= '0;
        m2_q   <= '0;
        sum2_q <= '0;
        w2_q   <= '0;
        wp2_q  <= '0;
        a3_q   <= '0;
        sum3_q <= '0;
        qh3_q  <= '0;
        lo3_q  <= '0;
        ca_q   <= '0;
        cb_q   <= '0;
      end else begin
        if (in_valid) begin
          a1_q  <= cin_a[k*WIDTH +: WIDTH];
          b1_q  <= cin_b[k*WIDTH +: WIDTH];
          w1_q  <= w[k*WIDTH +: WIDTH];
          wp1_q <= wp[k*WIDTH +: WIDTH];
        end
        if (v1_q) begin
          a2_q   <= a1_q;
          m2_q   <= m2_d;
          sum2_q <= sum2_d;
          w2_q   <= w1_q;
          wp2_q  <= wp1_q;
        end
        if (v2_q) begin
          a3_q   <= a2_q;
          sum3_q <= sum2_q;
          qh3_q  <= qh3_d;
          lo3_q  <= lo3_d;
        end
        if (v3_q) begin
          ca_q <= ca_d;
          cb_q <= cb_d;
        end
      end
    end

    assign cout_a[k*WIDTH +: WIDTH] = ca_q;
    assign cout_b[k*WIDTH +: WIDTH] = cb_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ntt_butterfly_array.sv
// Scoreboard bench for ntt_butterfly_array: one LANES=1 and one LANES=4 instance
// driven in lockstep, lane 0 shared.
`default_nettype none

module tb_ntt_butterfly_array;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         mode;
  logic [127:0] a4, b4, w4, wp4;
  logic [31:0]  q;
  logic [31:0]  a1, b1, w1, wp1;

  logic         ov1, busy1, ov4, busy4;
  logic [31:0]  ca1, cb1;
  logic [127:0] ca4, cb4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [127:0] ea;
    logic [127:0] eb;
    int           cap;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  assign a1  = a4[31:0];
  assign b1  = b4[31:0];
  assign w1  = w4[31:0];
  assign wp1 = wp4[31:0];

  ntt_butterfly_array #(.WIDTH(32), .LANES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
    .cin_a(a1), .cin_b(b1), .w(w1), .wp(wp1), .q(q),
    .out_valid(ov1), .cout_a(ca1), .cout_b(cb1), .busy(busy1)
  );

  ntt_butterfly_array #(.WIDTH(32), .LANES(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
    .cin_a(a4), .cin_b(b4), .w(w4), .wp(wp4), .q(q),
    .out_valid(ov4), .cout_a(ca4), .cout_b(cb4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mulm(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] m);
    return 32'((64'(x) * 64'(y)) % 64'(m));
  endfunction

  function automatic logic [31:0] addm(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] m);
    return 32'((64'(x) + 64'(y)) % 64'(m));
  endfunction

  function automatic logic [31:0] subm(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] m);
    return 32'((64'(x) + 64'(m) - 64'(y)) % 64'(m));
  endfunction

  function automatic logic [31:0] shoup(input logic [31:0] ww, input logic [31:0] m);
    logic [63:0] num;
    num = {ww, 32'h0};
    return 32'(num / 64'(m));
  endfunction

  // Output monitor: pops the scoreboard on every valid result.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (ov1 !== ov4) begin
        errors++;
        $display("FAIL valid_agree: lanes1=%b lanes4=%b", ov1, ov4);
      end
      if (ov4 === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: out_valid=1 with no beat pending at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (ca4 !== e.ea || cb4 !== e.eb) begin
            errors++;
            $display("FAIL data4: a=%h b=%h expected a=%h b=%h", ca4, cb4, e.ea, e.eb);
          end
          checks++;
          if (cyc !== e.cap + 3) begin
            errors++;
            $display("FAIL latency: out at cycle %0d, expected %0d", cyc, e.cap + 3);
          end
          checks++;
          if (ca1 !== e.ea[31:0] || cb1 !== e.eb[31:0]) begin
            errors++;
            $display("FAIL data1: a=%0d b=%0d expected a=%0d b=%0d",
                     ca1, cb1, e.ea[31:0], e.eb[31:0]);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the capture edge.
  task automatic drive_beat(input logic md, input logic [127:0] aa,
                            input logic [127:0] bb, input logic [127:0] ww);
    exp_t e;
    logic [31:0] ak, bk, wk, t;
    for (int k = 0; k < 4; k++) begin
      ak = aa[k*32 +: 32];
      bk = bb[k*32 +: 32];
      wk = ww[k*32 +: 32];
      wp4[k*32 +: 32] = shoup(wk, q);
      if (!md) begin
        t = mulm(bk, wk, q);
        e.ea[k*32 +: 32] = addm(ak, t, q);
        e.eb[k*32 +: 32] = subm(ak, t, q);
      end else begin
        e.ea[k*32 +: 32] = addm(ak, bk, q);
        e.eb[k*32 +: 32] = mulm(subm(ak, bk, q), wk, q);
      end
    end
    mode     = md;
    a4       = aa;
    b4       = bb;
    w4       = ww;
    in_valid = 1'b1;
    e.cap    = cyc + 1;
    sb.push_back(e);
    last_e = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats never emerged", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov4 !== 1'b0 || busy4 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drain: out_valid=%b busy4=%b busy1=%b expected 0 0 0",
               ov4, busy4, busy1);
    end
    checks++;
    if (ca4 !== last_e.ea || cb4 !== last_e.eb) begin
      errors++;
      $display("FAIL hold_on_bubble: a=%h b=%h expected a=%h b=%h",
               ca4, cb4, last_e.ea, last_e.eb);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (ov1 !== 1'b0 || ov4 !== 1'b0 || busy1 !== 1'b0 || busy4 !== 1'b0 ||
        ca1 !== 32'd0 || cb1 !== 32'd0 || ca4 !== 128'd0 || cb4 !== 128'd0) begin
      errors++;
      $display("FAIL reset_state: ov=%b/%b busy=%b/%b ca1=%0d cb1=%0d expected all 0",
               ov1, ov4, busy1, busy4, ca1, cb1);
    end
  endtask

  task automatic test_single_ct();
    q = 32'd17;
    drive_beat(1'b0, 128'd5, 128'd7, 128'd3);
    wait_drain();
    checks++;
    if (ca1 !== 32'd9 || cb1 !== 32'd1) begin
      errors++;
      $display("FAIL single_ct: a=%0d b=%0d expected a=9 b=1", ca1, cb1);
    end
  endtask

  task automatic test_single_gs();
    q = 32'd17;
    drive_beat(1'b1, 128'd5, 128'd7, 128'd3);
    wait_drain();
    checks++;
    if (ca1 !== 32'd12 || cb1 !== 32'd11) begin
      errors++;
      $display("FAIL single_gs: a=%0d b=%0d expected a=12 b=11", ca1, cb1);
    end
  endtask

  task automatic test_wrap_zero();
    q = 32'd17;
    drive_beat(1'b0, 128'd0, 128'd16, 128'd16);
    wait_drain();
    checks++;
    if (ca1 !== 32'd1 || cb1 !== 32'd16) begin
      errors++;
      $display("FAIL wrap_ct: a=%0d b=%0d expected a=1 b=16", ca1, cb1);
    end
    drive_beat(1'b0, 128'd0, 128'd0, 128'd1);
    wait_drain();
    checks++;
    if (ca1 !== 32'd0 || cb1 !== 32'd0) begin
      errors++;
      $display("FAIL zero_ct: a=%0d b=%0d expected a=0 b=0", ca1, cb1);
    end
  endtask

  task automatic test_lanes();
    logic [127:0] aa, bb, ww;
    q  = 32'd17;
    aa = {32'd0,  32'd13, 32'd2,  32'd5};
    bb = {32'd16, 32'd4,  32'd11, 32'd7};
    ww = {32'd16, 32'd9,  32'd15, 32'd3};
    drive_beat(1'b0, aa, bb, ww);
    wait_drain();
    checks++;
    if (ca4[31:0] !== 32'd9 || cb4[31:0] !== 32'd1 ||
        ca4[127:96] !== 32'd1 || cb4[127:96] !== 32'd16) begin
      errors++;
      $display("FAIL lanes_ct: lane0 a=%0d b=%0d lane3 a=%0d b=%0d expected 9 1 1 16",
               ca4[31:0], cb4[31:0], ca4[127:96], cb4[127:96]);
    end
    drive_beat(1'b1, aa, bb, ww);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [127:0] aa, bb, ww;
    q = ($urandom & 32'h7fff_ffff) | 32'h1;
    if (q < 32'd3) q = 32'h7fff_ffff;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) begin
        aa[k*32 +: 32] = $urandom % q;
        bb[k*32 +: 32] = $urandom % q;
        ww[k*32 +: 32] = $urandom % q;
      end
      drive_beat(i[0], aa, bb, ww);
    end
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    q = 32'd17;
    drive_beat(1'b0, 128'd1, 128'd2, 128'd3);
    drive_beat(1'b1, 128'd4, 128'd5, 128'd6);
    drive_beat(1'b0, 128'd7, 128'd8, 128'd9);
    sb.delete();
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL busy_inflight: busy=%b expected 1", busy4);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ov1 !== 1'b0 || ov4 !== 1'b0 || busy1 !== 1'b0 || busy4 !== 1'b0 ||
        ca4 !== 128'd0 || cb4 !== 128'd0 || ca1 !== 32'd0 || cb1 !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: ov=%b busy=%b ca4=%h cb4=%h expected all 0",
               ov4, busy4, ca4, cb4);
    end
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (busy4 !== 1'b0 || ca4 !== 128'd0) begin
      errors++;
      $display("FAIL discarded_beats: busy=%b ca4=%h expected 0 0", busy4, ca4);
    end
    drive_beat(1'b0, 128'd5, 128'd7, 128'd3);
    wait_drain();
    checks++;
    if (ca1 !== 32'd9 || cb1 !== 32'd1) begin
      errors++;
      $display("FAIL post_reset_beat: a=%0d b=%0d expected a=9 b=1", ca1, cb1);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    a4       = '0;
    b4       = '0;
    w4       = '0;
    wp4      = '0;
    q        = 32'd17;
    #12;
    test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_single_ct();
    test_single_gs();
    test_wrap_zero();
    test_lanes();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
